// File: rtl/pkt_filter_queue_if.sv
// Header/dispatch bundle between the packet decoder, the filter queue and the
// downstream units it enables.
interface pkt_filter_queue_if #(
  parameter int unsigned WORD_WIDTH = 16,
  parameter int unsigned CNT_W      = 8
);
  logic                  newpkt;
  logic [2:0]            fPktType;
  logic [WORD_WIDTH-1:0] destinationID;
  logic [WORD_WIDTH-1:0] myNodeID;
  logic                  unit_done;
  logic                  pkt_ready;
  logic                  en_QTU;
  logic                  en_MNI;
  logic                  en_KCH;
  logic                  en_reward;
  logic                  iAmDestination;
  logic                  busy;
  logic [CNT_W-1:0]      dropCount;
  logic                  overflow;
  logic                  timeout;

  modport master (
    output newpkt, fPktType, destinationID, myNodeID, unit_done,
    input  pkt_ready, en_QTU, en_MNI, en_KCH, en_reward, iAmDestination,
           busy, dropCount, overflow, timeout
  );

  modport slave (
    input  newpkt, fPktType, destinationID, myNodeID, unit_done,
    output pkt_ready, en_QTU, en_MNI, en_KCH, en_reward, iAmDestination,
           busy, dropCount, overflow, timeout
  );
endinterface

// File: rtl/pkt_filter_queue.sv
// Packet header filter: FIFO-buffered headers are matched against the node ID
// and dispatched as held unit enables until done or timeout.
module pkt_filter_queue #(
  parameter int unsigned           WORD_WIDTH = 16,
  parameter int unsigned           DEPTH      = 4,
  parameter logic [WORD_WIDTH-1:0] BCAST_ID   = WORD_WIDTH'(16'hFFFF),
  parameter bit                    PROMISC    = 1'b0,
  parameter int unsigned           TIMEOUT    = 64,
  parameter int unsigned           CNT_W      = 8
) (
  input logic              clk,
  input logic              rst,
  pkt_filter_queue_if.slave pkt
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned EW = 3 + WORD_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DECODE,
    S_WAIT
  } state_t;

  typedef enum logic [2:0] {
    PT_HB   = 3'b000,
    PT_CHE  = 3'b001,
    PT_INV  = 3'b010,
    PT_MR   = 3'b011,
    PT_CHT  = 3'b100,
    PT_DATA = 3'b101,
    PT_SOS  = 3'b110,
    PT_BAD  = 3'b111
  } pkt_type_t;

  // FIFO storage and pointers
  logic [EW-1:0]  mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW:0]    fill;
  logic           full;
  logic           empty;
  logic           push;
  logic           pop;
  logic           ovf_drop;
  logic [EW-1:0]  head;

  // FSM state and working header
  state_t                state;
  pkt_type_t             work_type;
  logic [WORD_WIDTH-1:0] work_dest;
  logic [TW-1:0]         wait_cnt;
  logic [3:0]            en;
  logic                  iam;
  logic                  timeout_q;
  logic [CNT_W-1:0]      drop_cnt;
  logic                  overflow_q;

  // Decode results, ordered {QTU, MNI, KCH, reward}
  logic                  match;
  logic [3:0]            dec_en;
  logic                  fsm_drop;
  logic                  wait_expired;
  logic [CNT_W:0]        drop_sum;

  assign full     = (fill == (AW+1)'(DEPTH));
  assign empty    = (fill == '0);
  assign pop      = (state == S_IDLE) && !empty;
  assign push     = pkt.newpkt && (!full || pop);
  assign ovf_drop = pkt.newpkt && full && !pop;
  assign head     = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {pkt.fPktType, pkt.destinationID};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fill <= fill + 1'b1;
        2'b01:   fill <= fill - 1'b1;
        default: fill <= fill;
      endcase
    end
  end

  always_comb begin
    match  = PROMISC || (work_dest == pkt.myNodeID) || (work_dest == BCAST_ID);
    dec_en = '0;
    unique case (work_type)
      PT_HB, PT_SOS: dec_en = 4'b0101;
      PT_CHE:        if (match) dec_en = 4'b0010;
      PT_INV:        dec_en = 4'b0010;
      PT_MR:         if (match) dec_en = 4'b0100;
      PT_CHT:        if (match) dec_en = 4'b1000;
      PT_DATA:       dec_en = 4'b1000;
      default:       dec_en = '0;
    endcase
  end

  assign wait_expired = (wait_cnt == TW'(TIMEOUT - 1));
  assign fsm_drop     = ((state == S_DECODE) && (dec_en == '0)) ||
                        ((state == S_WAIT) && !pkt.unit_done && wait_expired);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      work_type <= PT_HB;
      work_dest <= '0;
      wait_cnt  <= '0;
      en        <= '0;
      iam       <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (pop) begin
            work_type <= pkt_type_t'(head[EW-1 -: 3]);
            work_dest <= head[WORD_WIDTH-1:0];
            state     <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (dec_en != '0) begin
            en       <= dec_en;
            iam      <= match;
            wait_cnt <= '0;
            state    <= S_WAIT;
          end else begin
            state    <= S_IDLE;
          end
        end
        S_WAIT: begin
          if (pkt.unit_done) begin
            en    <= '0;
            iam   <= 1'b0;
            state <= S_IDLE;
          end else if (wait_expired) begin
            en        <= '0;
            iam       <= 1'b0;
            timeout_q <= 1'b1;
            state     <= S_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // An overflow and an FSM discard can coincide, so the count may step by two
  assign drop_sum = {1'b0, drop_cnt} + (CNT_W+1)'(ovf_drop) + (CNT_W+1)'(fsm_drop);

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt   <= '0;
      overflow_q <= 1'b0;
    end else begin
      drop_cnt <= drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
      if (ovf_drop) overflow_q <= 1'b1;
    end
  end

  assign pkt.pkt_ready      = !full;
  assign pkt.busy           = (state != S_IDLE) || !empty;
  assign pkt.en_QTU         = en[3];
  assign pkt.en_MNI         = en[2];
  assign pkt.en_KCH         = en[1];
  assign pkt.en_reward      = en[0];
  assign pkt.iAmDestination = iam;
  assign pkt.dropCount      = drop_cnt;
  assign pkt.overflow       = overflow_q;
  assign pkt.timeout        = timeout_q;

endmodule

// File: tb/tb_pkt_filter_queue.sv
// Directed bench for pkt_filter_queue: default build plus a PROMISC build fed
// the same header stream.
module tb_pkt_filter_queue;

  localparam logic [2:0] HB = 3'b000, CHE = 3'b001, INV = 3'b010, MR = 3'b011;
  localparam logic [2:0] CHT = 3'b100, DATA = 3'b101, SOS = 3'b110;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_bad;

  pkt_filter_queue_if #(.WORD_WIDTH(16), .CNT_W(8)) p0 ();
  pkt_filter_queue_if #(.WORD_WIDTH(16), .CNT_W(8)) p1 ();

  pkt_filter_queue #(.WORD_WIDTH(16), .DEPTH(4), .PROMISC(1'b0), .TIMEOUT(64), .CNT_W(8))
    u_dut (.clk(clk), .rst(rst), .pkt(p0));

  pkt_filter_queue #(.WORD_WIDTH(16), .DEPTH(4), .PROMISC(1'b1), .TIMEOUT(64), .CNT_W(8))
    u_prom (.clk(clk), .rst(rst), .pkt(p1));

  assign p1.newpkt        = p0.newpkt;
  assign p1.fPktType      = p0.fPktType;
  assign p1.destinationID = p0.destinationID;
  assign p1.myNodeID      = p0.myNodeID;
  assign p1.unit_done     = p0.unit_done;

  logic [3:0] en0, en1;
  assign en0 = {p0.en_QTU, p0.en_MNI, p0.en_KCH, p0.en_reward};
  assign en1 = {p1.en_QTU, p1.en_MNI, p1.en_KCH, p1.en_reward};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [2:0] t, input logic [15:0] d);
    p0.fPktType      = t;
    p0.destinationID = d;
    p0.newpkt        = 1'b1;
    tick(1);
    p0.newpkt        = 1'b0;
  endtask

  task automatic done_pulse();
    p0.unit_done = 1'b1;
    tick(1);
    p0.unit_done = 1'b0;
  endtask

  initial begin
    int hi;
    int pulses;
    n_chk = 0;
    n_bad = 0;
    rst              = 1'b1;
    p0.newpkt        = 1'b0;
    p0.fPktType      = 3'b000;
    p0.destinationID = 16'h0000;
    p0.myNodeID      = 16'h000C;
    p0.unit_done     = 1'b0;
    tick(3);
    rst = 1'b0;

    check("rst_en",       32'(en0), 32'h0);
    check("rst_ready",    32'(p0.pkt_ready), 32'h1);
    check("rst_busy",     32'(p0.busy), 32'h0);
    check("rst_drop",     32'(p0.dropCount), 32'h0);
    check("rst_ovf",      32'(p0.overflow), 32'h0);
    check("rst_timeout",  32'(p0.timeout), 32'h0);

    // HB to a foreign node: MNI + reward, not for us
    send(HB, 16'h0000);
    tick(1);
    check("hb_early_en", 32'(en0), 32'h0);
    tick(1);
    check("hb_en",   32'(en0), 32'h5);
    check("hb_iam",  32'(p0.iAmDestination), 32'h0);
    check("hb_busy", 32'(p0.busy), 32'h1);
    done_pulse();
    check("hb_done_en",   32'(en0), 32'h0);
    check("hb_done_busy", 32'(p0.busy), 32'h0);

    send(CHE, 16'h0008);
    tick(2);
    check("che_miss_en",   32'(en0), 32'h0);
    check("che_miss_drop", 32'(p0.dropCount), 32'h1);
    check("che_miss_busy", 32'(p0.busy), 32'h0);

    send(CHE, 16'h000C);
    tick(2);
    check("che_hit_en",  32'(en0), 32'h2);
    check("che_hit_iam", 32'(p0.iAmDestination), 32'h1);
    done_pulse();

    send(DATA, 16'h000D);
    tick(2);
    check("data_fwd_en",  32'(en0), 32'h8);
    check("data_fwd_iam", 32'(p0.iAmDestination), 32'h0);
    done_pulse();

    send(DATA, 16'hFFFF);
    tick(2);
    check("data_bc_en",  32'(en0), 32'h8);
    check("data_bc_iam", 32'(p0.iAmDestination), 32'h1);
    done_pulse();

    // Park the FSM in WAIT so the burst below only fills the FIFO
    send(HB, 16'h0000);
    tick(2);
    check("park_en", 32'(en0), 32'h5);
    send(MR,   16'h000C);
    send(CHT,  16'h000C);
    send(INV,  16'h0005);
    send(SOS,  16'h0000);
    check("full_ready", 32'(p0.pkt_ready), 32'h0);
    check("full_ovf",   32'(p0.overflow), 32'h0);
    send(DATA, 16'h000C);
    check("ovf_flag", 32'(p0.overflow), 32'h1);
    check("ovf_drop", 32'(p0.dropCount), 32'h2);
    check("ovf_held_en", 32'(en0), 32'h5);

    done_pulse();
    tick(2);
    check("q0_en",    32'(en0), 32'h4);
    check("q0_iam",   32'(p0.iAmDestination), 32'h1);
    check("q0_ready", 32'(p0.pkt_ready), 32'h1);
    done_pulse();
    tick(2);
    check("q1_en",  32'(en0), 32'h8);
    check("q1_iam", 32'(p0.iAmDestination), 32'h1);
    done_pulse();
    tick(2);
    check("q2_en",  32'(en0), 32'h2);
    check("q2_iam", 32'(p0.iAmDestination), 32'h0);
    done_pulse();
    tick(2);
    check("q3_en",  32'(en0), 32'h5);
    check("q3_iam", 32'(p0.iAmDestination), 32'h0);
    done_pulse();
    tick(2);
    check("q_empty_en",   32'(en0), 32'h0);
    check("q_empty_busy", 32'(p0.busy), 32'h0);
    check("ovf_sticky",   32'(p0.overflow), 32'h1);

    // MR for us, never acknowledged
    send(MR, 16'h000C);
    tick(2);
    hi = 0;
    pulses = 0;
    for (int i = 0; i < 90; i++) begin
      if (p0.en_MNI) hi++;
      if (p0.timeout) pulses++;
      tick(1);
    end
    check("to_held",   32'(hi), 32'd64);
    check("to_pulses", 32'(pulses), 32'd1);
    check("to_drop",   32'(p0.dropCount), 32'h3);
    check("to_en",     32'(en0), 32'h0);

    // Reset in WAIT with two headers queued
    send(MR, 16'h000C);
    tick(2);
    send(INV, 16'h0005);
    send(SOS, 16'h0000);
    check("pre_rst_en",   32'(en0), 32'h4);
    check("pre_rst_busy", 32'(p0.busy), 32'h1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("mid_rst_en",    32'(en0), 32'h0);
    check("mid_rst_ready", 32'(p0.pkt_ready), 32'h1);
    check("mid_rst_busy",  32'(p0.busy), 32'h0);
    check("mid_rst_drop",  32'(p0.dropCount), 32'h0);
    check("mid_rst_ovf",   32'(p0.overflow), 32'h0);
    tick(3);
    check("post_rst_en", 32'(en0), 32'h0);

    // Same CHE miss: default build drops it, PROMISC build dispatches it
    send(CHE, 16'h0008);
    tick(2);
    check("std_che_en",   32'(en0), 32'h0);
    check("std_che_drop", 32'(p0.dropCount), 32'h1);
    check("prom_che_en",  32'(en1), 32'h2);
    check("prom_che_drop", 32'(p1.dropCount), 32'h0);
    done_pulse();
    check("prom_done_en", 32'(en1), 32'h0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
